// File: rtl/aximm_rx_ctrl.sv
// Receive-side AXI-ST controller: two-entry skid buffer feeding a write-side FIFO,
// with a registered upstream ready, a written-beat counter and a sticky protocol flag.
//
// state | meaning
// EMPTY | no beat buffered
// ONE   | out register holds the oldest beat
// TWO   | out and skid registers both hold beats; upstream ready is low
module aximm_rx_ctrl #(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              axist_valid,
  input  logic [DWIDTH-1:0] axist_data,
  output logic              axist_rdy,
  input  logic              fifo_full,
  output logic              fifo_wren,
  output logic [DWIDTH-1:0] fifo_wdata,
  output logic [CNT_W-1:0]  rx_beat_cnt,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DWIDTH-1:0] out_data;
  logic [DWIDTH-1:0] skid_data;
  logic [DWIDTH-1:0] out_data_nxt;
  logic [DWIDTH-1:0] skid_data_nxt;
  logic              accept;
  logic              drain;
  logic              stall_q;
  logic [DWIDTH-1:0] data_q;
  logic              viol;

  assign accept     = axist_valid & axist_rdy;
  assign drain      = (state != EMPTY) & ~fifo_full;
  assign fifo_wren  = drain;
  assign fifo_wdata = out_data;

  // A beat offered without ready must stay valid and stable until taken.
  assign viol = stall_q & (~axist_valid | (axist_data != data_q));

  always_comb begin
    next_state    = state;
    out_data_nxt  = out_data;
    skid_data_nxt = skid_data;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state   = ONE;
          out_data_nxt = axist_data;
        end
      end
      ONE: begin
        if (accept && drain) begin
          out_data_nxt = axist_data;
        end else if (accept) begin
          next_state    = TWO;
          skid_data_nxt = axist_data;
        end else if (drain) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          next_state   = ONE;
          out_data_nxt = skid_data;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_data    <= '0;
      skid_data   <= '0;
      axist_rdy   <= 1'b0;
      rx_beat_cnt <= '0;
      stall_q     <= 1'b0;
      data_q      <= '0;
      proto_err   <= 1'b0;
    end else begin
      state     <= next_state;
      out_data  <= out_data_nxt;
      skid_data <= skid_data_nxt;
      axist_rdy <= (next_state != TWO);
      if (drain) begin
        rx_beat_cnt <= rx_beat_cnt + CNT_W'(1);
      end
      stall_q <= axist_valid & ~axist_rdy;
      data_q  <= axist_data;
      if (viol) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aximm_rx_ctrl.sv
// Directed bench for aximm_rx_ctrl: a default-width instance plus a CNT_W=4 instance
// sharing the same stimulus, so counter wrap is visible alongside the main checks.
module tb_aximm_rx_ctrl;

  logic        clk;
  logic        rst_n;
  logic        axist_valid;
  logic [31:0] axist_data;
  logic        fifo_full;

  logic        axist_rdy;
  logic        fifo_wren;
  logic [31:0] fifo_wdata;
  logic [15:0] rx_beat_cnt;
  logic        proto_err;

  logic        rdy4;
  logic        wren4;
  logic [31:0] wdata4;
  logic [3:0]  cnt4;
  logic        perr4;

  int vectors;
  int miscompares;
  int idx;
  logic acc;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  aximm_rx_ctrl #(.DWIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .axist_valid(axist_valid), .axist_data(axist_data),
    .axist_rdy(axist_rdy), .fifo_full(fifo_full), .fifo_wren(fifo_wren),
    .fifo_wdata(fifo_wdata), .rx_beat_cnt(rx_beat_cnt), .proto_err(proto_err)
  );

  aximm_rx_ctrl #(.DWIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .axist_valid(axist_valid), .axist_data(axist_data),
    .axist_rdy(rdy4), .fifo_full(fifo_full), .fifo_wren(wren4),
    .fifo_wdata(wdata4), .rx_beat_cnt(cnt4), .proto_err(perr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && fifo_wren) got_q.push_back(fifo_wdata);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_beat%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    axist_valid = 1'b0;
    axist_data = '0;
    fifo_full = 1'b0;
    #3;
    check("rst_rdy", 64'(axist_rdy), 64'd0);
    check("rst_wren", 64'(fifo_wren), 64'd0);
    check("rst_cnt", 64'(rx_beat_cnt), 64'd0);
    check("rst_perr", 64'(proto_err), 64'd0);
    check("rst_wdata", 64'(fifo_wdata), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    check("rel_rdy_low", 64'(axist_rdy), 64'd0);
    step();
    check("rel_rdy_high", 64'(axist_rdy), 64'd1);

    // single beat
    axist_valid = 1'b1;
    axist_data = 32'hA5A5_0001;
    step();
    axist_valid = 1'b0;
    check("single_wren", 64'(fifo_wren), 64'd1);
    check("single_wdata", 64'(fifo_wdata), 64'hA5A5_0001);
    check("single_cnt_pre", 64'(rx_beat_cnt), 64'd0);
    step();
    check("single_cnt", 64'(rx_beat_cnt), 64'd1);
    check("single_cnt4", 64'(cnt4), 64'd1);
    check("single_idle", 64'(fifo_wren), 64'd0);
    exp_q.push_back(32'hA5A5_0001);

    // 16-beat burst; narrow counter passes 15 -> 0 -> 1 over 17 total writes
    for (int i = 0; i < 16; i++) begin
      axist_valid = 1'b1;
      axist_data = 32'(i);
      check($sformatf("burst_rdy%0d", i), 64'(axist_rdy), 64'd1);
      step();
      check($sformatf("burst_wren%0d", i), 64'(fifo_wren), 64'd1);
      check($sformatf("burst_wdata%0d", i), 64'(fifo_wdata), 64'(i));
      check($sformatf("burst_wdata4_%0d", i), 64'(wdata4), 64'(i));
      check($sformatf("burst_cnt4_%0d", i), 64'(cnt4), 64'((1 + i) % 16));
      exp_q.push_back(32'(i));
    end
    axist_valid = 1'b0;
    step();
    check("burst_cnt", 64'(rx_beat_cnt), 64'd17);
    check("burst_cnt4_wrap", 64'(cnt4), 64'd1);
    check("burst_idle", 64'(fifo_wren), 64'd0);
    check_stream("burst");

    // backpressure: fifo_full for cycles 3..7 of a 16-beat stream
    got_q.delete();
    exp_q.delete();
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      fifo_full = (c >= 3 && c < 8);
      if (idx < 16) begin
        axist_valid = 1'b1;
        axist_data = 32'h100 + 32'(idx);
      end else begin
        axist_valid = 1'b0;
      end
      @(negedge clk);
      acc = axist_valid & axist_rdy;
      if (c == 4) begin
        check("bp_rdy_drop", 64'(axist_rdy), 64'd0);
        check("bp_wren_held", 64'(fifo_wren), 64'd0);
        check("bp_wdata_held", 64'(fifo_wdata), 64'h102);
      end
      if (c == 7) check("bp_wdata_c7", 64'(fifo_wdata), 64'h102);
      if (c == 8) begin
        check("bp_rdy_still_low", 64'(axist_rdy), 64'd0);
        check("bp_resume_wren", 64'(fifo_wren), 64'd1);
        check("bp_resume_wdata", 64'(fifo_wdata), 64'h102);
      end
      if (c == 9) begin
        check("bp_rdy_back", 64'(axist_rdy), 64'd1);
        check("bp_next_wdata", 64'(fifo_wdata), 64'h103);
      end
      step();
      if (acc) idx++;
    end
    check("bp_all_accepted", 64'(idx), 64'd16);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(i));
    check_stream("bp");
    check("bp_cnt", 64'(rx_beat_cnt), 64'd33);
    check("bp_perr", 64'(proto_err), 64'd0);

    // async reset while two beats are buffered
    got_q.delete();
    exp_q.delete();
    fifo_full = 1'b1;
    axist_valid = 1'b1;
    axist_data = 32'h11;
    step();
    axist_data = 32'h22;
    step();
    axist_valid = 1'b0;
    fifo_full = 1'b0;
    #1;
    check("two_rdy", 64'(axist_rdy), 64'd0);
    check("two_wren", 64'(fifo_wren), 64'd1);
    check("two_wdata", 64'(fifo_wdata), 64'h11);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_wren", 64'(fifo_wren), 64'd0);
    check("arst_rdy", 64'(axist_rdy), 64'd0);
    check("arst_cnt", 64'(rx_beat_cnt), 64'd0);
    check("arst_cnt4", 64'(cnt4), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    check("arst_no_writes", 64'(got_q.size()), 64'd0);
    check("arst_cnt_after", 64'(rx_beat_cnt), 64'd0);
    check("arst_rdy_after", 64'(axist_rdy), 64'd1);

    // protocol violation: data changes while stalled
    got_q.delete();
    exp_q.delete();
    fifo_full = 1'b1;
    axist_valid = 1'b1;
    axist_data = 32'h1;
    step();
    axist_data = 32'h2;
    step();
    axist_data = 32'h5;
    check("pe_rdy_low", 64'(axist_rdy), 64'd0);
    step();
    axist_data = 32'h6;
    check("pe_not_yet", 64'(proto_err), 64'd0);
    step();
    check("pe_set", 64'(proto_err), 64'd1);
    check("pe_set4", 64'(perr4), 64'd1);
    fifo_full = 1'b0;
    step();
    step();
    axist_valid = 1'b0;
    repeat (4) step();
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h6);
    check_stream("pe");
    check("pe_sticky", 64'(proto_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("pe_cleared", 64'(proto_err), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
